sfp_telemetry_rx: RTL and testbench
===================================

// Module: sfp_telemetry_rx
// PURPOSE
//  Master-side (sfp_id 0) receiver for slave telemetry bursts on the 64-bit SFP RX stream.
//  Each burst is 9 frames, STAT..PH_T, with index 0..8. A slave sends one burst roughly every 4001 clocks.
//  The block routes frames by slave id 1..3 into shadow banks and commits a bank atomically when the burst completes.
//  It tracks slave liveness and sequence errors, and forwards every non-telemetry frame to a response FIFO for the PS.
// PARAMETERS
//  P_ALIVE_TO   12000  clocks without a committed burst before a slave is declared dead
//  P_BURST_TO   16     max clocks between consecutive frames of one slave inside a burst
//  P_RSP_DEPTH  4      response FIFO depth (power of 2)
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   reset, asynchronous, active-low
//  i_channel_up     in   1   Aurora channel up
//  i_sfp_master     in   1   this node is master (sfp_en && id==0); block is inert when low
//  s_rx_tdata       in   64  RX frame
//  s_rx_tvalid      in   1   RX frame valid
//  s_rx_tready      out  1   constant 1
//  m_rsp_tdata      out  64  non-telemetry frame to PS
//  m_rsp_tvalid     out  1   response FIFO not empty
//  m_rsp_tready     in   1   PS pop
//  i_rd_slave       in   2   readback slave id (1..3)
//  i_rd_idx         in   4   readback word index (0..8)
//  o_rd_data        out  32  committed word
//  o_update         out  3   one-clock pulse per slave [id-1] on commit
//  o_alive          out  3   slave [id-1] alive
//  o_seq_err_cnt    out  16  saturating sequence-error count, all slaves
//  o_rsp_drop_cnt   out  16  saturating response-FIFO overflow count
// BEHAVIOUR
//  Frame acceptance:
//   - Accept = s_rx_tvalid && i_sfp_master; s_rx_tready=1 always.
//   - hdr = tdata[63:32]. Telemetry frame iff hdr[31:30]==0, hdr[27:4]==24'h200000, hdr[3:0]<=8 and id=hdr[29:28]!=0.
//   - All other accepted frames, including id 0, push into the response FIFO.
//  Per-slave FSM (x3), states IDLE and COLLECT; exp = 4-bit expected index; gap = gap counter:
//   - IDLE, idx==0: store shadow[0], exp<=1, COLLECT.
//   - IDLE, idx!=0: seq_err++, stay IDLE.
//   - COLLECT, idx==exp: store, exp++, gap<=0. If idx==8: copy all 9 shadows to the committed bank, pulse o_update, IDLE.
//   - COLLECT, idx==0: seq_err++, restart (store shadow[0], exp<=1).
//   - COLLECT, any other idx: seq_err++, discard, IDLE.
//   - COLLECT, no frame for this slave for P_BURST_TO clocks: seq_err++, IDLE.
//   - Partial bursts never alter the committed bank.
//  Channel and mode changes:
//   - If i_channel_up or i_sfp_master is low: all FSMs -> IDLE, shadows discarded, no seq_err.
//   - Committed banks, counters and the FIFO are retained.
//  Liveness:
//   - 16-bit per-slave counter: cleared on commit, otherwise +1, saturating at P_ALIVE_TO.
//   - o_alive[i] = cnt < P_ALIVE_TO.
//  Readback:
//   - o_rd_data is registered, 1-clock latency, and returns the committed bank as of the previous edge.
//   - A commit in the same cycle is visible on the next read.
//   - Returns 0 for i_rd_slave==0 or i_rd_idx>8.
//  Response FIFO:
//   - First-word fall-through: m_rsp_tdata is the head, m_rsp_tvalid = !empty.
//   - Pop on tvalid&&tready. Push is accepted when not full, or when full with a pop in the same cycle.
//   - Otherwise the frame is dropped and o_rsp_drop_cnt++.
//  Counters saturate at 16'hFFFF.
//  Reset values:
//   - All outputs 0 except s_rx_tready=1.
//   - Alive counters reset to P_ALIVE_TO, so o_alive=0 until a first commit.
//   - Committed banks 0, FSMs IDLE, FIFO empty.
// TESTING
//  T1: slave 1 burst, idx 0..8 with data 0xA0..0xA8, back-to-back -> o_update[0] pulses 1 clk after idx 8 frame; rd(1,5)=0xA5; o_alive[0]=1.
//  T2: slave 2 burst idx 0,1,2,4 -> seq_err_cnt=1; rd(2,*) stays at prior values; no o_update[1].
//  T3: interleaved slave 1 and slave 3 bursts on alternate cycles -> both commit correctly; seq_err_cnt=0.
//  T4: 5 frames with hdr 0x8000_0001 and m_rsp_tready=0 -> 4 held, o_rsp_drop_cnt=1; then tready=1 -> 4 frames pop in order.
//  T5: commit slave 1, then idle P_ALIVE_TO clocks -> o_alive[0] falls exactly at count P_ALIVE_TO.
//  T6: i_channel_up drops after idx 4 of slave 2, restore, full burst -> single commit, seq_err_cnt=0.
//      Also assert i_rst mid-burst -> all outputs return to reset values.

Source files
------------

// File: rtl/sfp_telemetry_rx_if.sv
// RX telemetry stream into the receiver and response stream out to the PS.
// Both streams: a beat transfers on a clock edge where tvalid && tready; the source holds tdata stable while tvalid is high and tready is low.
interface sfp_telemetry_rx_if;
  logic [63:0] s_rx_tdata;
  logic        s_rx_tvalid;
  logic        s_rx_tready;
  logic [63:0] m_rsp_tdata;
  logic        m_rsp_tvalid;
  logic        m_rsp_tready;

  modport slave (
    input  s_rx_tdata, s_rx_tvalid, m_rsp_tready,
    output s_rx_tready, m_rsp_tdata, m_rsp_tvalid
  );

  modport master (
    output s_rx_tdata, s_rx_tvalid, m_rsp_tready,
    input  s_rx_tready, m_rsp_tdata, m_rsp_tvalid
  );
endinterface

// File: rtl/sfp_telemetry_rx.sv
// Master-side SFP telemetry receiver: per-slave burst assembly into shadow banks with atomic commit,
// liveness and sequence-error tracking, and a FWFT response FIFO for non-telemetry frames.
module sfp_telemetry_rx #(
  parameter int P_ALIVE_TO  = 12000,
  parameter int P_BURST_TO  = 16,
  parameter int P_RSP_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_channel_up,
  input  logic                     i_sfp_master,
  sfp_telemetry_rx_if.slave        bus,
  input  logic [1:0]               i_rd_slave,
  input  logic [3:0]               i_rd_idx,
  output logic [31:0]              o_rd_data,
  output logic [2:0]               o_update,
  output logic [2:0]               o_alive,
  output logic [15:0]              o_seq_err_cnt,
  output logic [15:0]              o_rsp_drop_cnt,
  output logic [2:0]               o_dbg_collect
);
  localparam int AW = $clog2(P_RSP_DEPTH);
  localparam int GW = $clog2(P_BURST_TO) + 1;

  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  state_e      state_q [3], state_d [3];
  logic [3:0]  exp_q [3], exp_d [3];
  logic [GW-1:0] gap_q [3], gap_d [3];
  logic [31:0] shadow_q [3][9], shadow_d [3][9];
  logic [31:0] bank_q [3][9], bank_d [3][9];
  logic [15:0] alive_q [3], alive_d [3];
  logic [2:0]  update_q, update_d;
  logic [15:0] seq_err_q, seq_err_d, drop_q, drop_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [63:0] mem_q [P_RSP_DEPTH], mem_d [P_RSP_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;

  logic [31:0] hdr, frm_data;
  logic [1:0]  frm_id;
  logic [3:0]  frm_idx;
  logic        accept, is_tlm, live, hit, push_req, push, pop, fifo_empty, fifo_full;
  logic [1:0]  err_sum;
  logic [16:0] err_sum_ext;

  assign hdr      = bus.s_rx_tdata[63:32];
  assign frm_data = bus.s_rx_tdata[31:0];
  assign frm_id   = hdr[29:28];
  assign frm_idx  = hdr[3:0];
  assign accept   = bus.s_rx_tvalid && i_sfp_master;
  assign is_tlm   = (hdr[31:30] == 2'b00) && (hdr[27:4] == 24'h200000) &&
                    (frm_idx <= 4'd8) && (frm_id != 2'd0);
  // Any loss of channel or master role abandons in-flight bursts silently.
  assign live     = i_channel_up && i_sfp_master;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(P_RSP_DEPTH));
  assign pop        = !fifo_empty && bus.m_rsp_tready;
  assign push_req   = accept && !is_tlm;
  assign push       = push_req && (!fifo_full || pop);

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    gap_d       = gap_q;
    shadow_d    = shadow_q;
    bank_d      = bank_q;
    alive_d     = alive_q;
    update_d    = '0;
    err_sum     = '0;
    hit         = 1'b0;
    for (int s = 0; s < 3; s++) begin
      hit = accept && is_tlm && live && (frm_id == 2'(s + 1));
      if (alive_q[s] < 16'(P_ALIVE_TO)) alive_d[s] = alive_q[s] + 16'd1;
      if (!live) begin
        state_d[s] = S_IDLE;
        exp_d[s]   = '0;
        gap_d[s]   = '0;
      end else if (state_q[s] == S_IDLE) begin
        if (hit && frm_idx == 4'd0) begin
          shadow_d[s][0] = frm_data;
          exp_d[s]       = 4'd1;
          gap_d[s]       = '0;
          state_d[s]     = S_COLLECT;
        end else if (hit) begin
          err_sum = err_sum + 2'd1;
        end
      end else if (hit) begin
        gap_d[s] = '0;
        if (frm_idx == exp_q[s]) begin
          shadow_d[s][frm_idx] = frm_data;
          exp_d[s]             = exp_q[s] + 4'd1;
          if (frm_idx == 4'd8) begin
            // Index 8 is committed straight from the bus; shadow_q[8] is not yet written.
            for (int i = 0; i < 8; i++) bank_d[s][i] = shadow_q[s][i];
            bank_d[s][8] = frm_data;
            update_d[s]  = 1'b1;
            alive_d[s]   = '0;
            state_d[s]   = S_IDLE;
          end
        end else if (frm_idx == 4'd0) begin
          err_sum        = err_sum + 2'd1;
          shadow_d[s][0] = frm_data;
          exp_d[s]       = 4'd1;
        end else begin
          err_sum    = err_sum + 2'd1;
          state_d[s] = S_IDLE;
        end
      end else if (gap_q[s] == GW'(P_BURST_TO - 1)) begin
        err_sum    = err_sum + 2'd1;
        state_d[s] = S_IDLE;
      end else begin
        gap_d[s] = gap_q[s] + GW'(1);
      end
    end

    err_sum_ext = {1'b0, seq_err_q} + 17'(err_sum);
    seq_err_d   = err_sum_ext[16] ? 16'hFFFF : err_sum_ext[15:0];

    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    drop_d = drop_q;
    if (push) begin
      mem_d[wr_q] = bus.s_rx_tdata;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    if (push_req && !push && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    rd_data_d = '0;
    if (i_rd_idx <= 4'd8) begin
      case (i_rd_slave)
        2'd1:    rd_data_d = bank_q[0][i_rd_idx];
        2'd2:    rd_data_d = bank_q[1][i_rd_idx];
        2'd3:    rd_data_d = bank_q[2][i_rd_idx];
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= '{default: S_IDLE};
      exp_q     <= '{default: '0};
      gap_q     <= '{default: '0};
      shadow_q  <= '{default: '0};
      bank_q    <= '{default: '0};
      alive_q   <= '{default: 16'(P_ALIVE_TO)};
      update_q  <= '0;
      seq_err_q <= '0;
      drop_q    <= '0;
      rd_data_q <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      gap_q     <= gap_d;
      shadow_q  <= shadow_d;
      bank_q    <= bank_d;
      alive_q   <= alive_d;
      update_q  <= update_d;
      seq_err_q <= seq_err_d;
      drop_q    <= drop_d;
      rd_data_q <= rd_data_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.s_rx_tready  = 1'b1;
  assign bus.m_rsp_tvalid = !fifo_empty;
  assign bus.m_rsp_tdata  = fifo_empty ? 64'd0 : mem_q[rd_q];
  assign o_rd_data        = rd_data_q;
  assign o_update         = update_q;
  assign o_seq_err_cnt    = seq_err_q;
  assign o_rsp_drop_cnt   = drop_q;

  always_comb begin
    o_alive       = '0;
    o_dbg_collect = '0;
    for (int s = 0; s < 3; s++) begin
      o_alive[s]       = alive_q[s] < 16'(P_ALIVE_TO);
      o_dbg_collect[s] = (state_q[s] == S_COLLECT);
    end
  end
endmodule

// File: tb/tb_sfp_telemetry_rx.sv
// Directed bench for sfp_telemetry_rx: bursts, sequence errors, FIFO, channel loss, liveness, reset.
module tb_sfp_telemetry_rx;
  localparam int ALIVE_TO = 12000;
  localparam logic [31:0] RSP_HDR = 32'h8000_0001;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_channel_up = 1'b0;
  logic        i_sfp_master = 1'b0;
  logic [1:0]  i_rd_slave = '0;
  logic [3:0]  i_rd_idx = '0;
  logic [31:0] o_rd_data;
  logic [2:0]  o_update, o_alive, o_dbg_collect;
  logic [15:0] o_seq_err_cnt, o_rsp_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_err;
  logic [31:0] exp_heads [4];

  sfp_telemetry_rx_if bus ();

  sfp_telemetry_rx dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_channel_up   (i_channel_up),
    .i_sfp_master   (i_sfp_master),
    .bus            (bus),
    .i_rd_slave     (i_rd_slave),
    .i_rd_idx       (i_rd_idx),
    .o_rd_data      (o_rd_data),
    .o_update       (o_update),
    .o_alive        (o_alive),
    .o_seq_err_cnt  (o_seq_err_cnt),
    .o_rsp_drop_cnt (o_rsp_drop_cnt),
    .o_dbg_collect  (o_dbg_collect)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_raw(input logic [63:0] d);
    bus.s_rx_tdata  = d;
    bus.s_rx_tvalid = 1'b1;
    tick();
    bus.s_rx_tvalid = 1'b0;
  endtask

  task automatic send_tlm(input logic [1:0] id, input logic [3:0] idx, input logic [31:0] data);
    send_raw({2'b00, id, 24'h200000, idx, data});
  endtask

  task automatic rd(input string tag, input logic [1:0] s, input logic [3:0] idx, input logic [31:0] exp_v);
    i_rd_slave = s;
    i_rd_idx   = idx;
    tick();
    chk(tag, 64'(o_rd_data), 64'(exp_v));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rd"},     64'(o_rd_data), 64'd0);
    chk({tag, "_upd"},    64'(o_update), 64'd0);
    chk({tag, "_alive"},  64'(o_alive), 64'd0);
    chk({tag, "_err"},    64'(o_seq_err_cnt), 64'd0);
    chk({tag, "_drop"},   64'(o_rsp_drop_cnt), 64'd0);
    chk({tag, "_tvalid"}, 64'(bus.m_rsp_tvalid), 64'd0);
    chk({tag, "_tdata"},  bus.m_rsp_tdata, 64'd0);
    chk({tag, "_tready"}, 64'(bus.s_rx_tready), 64'd1);
    chk({tag, "_fsm"},    64'(o_dbg_collect), 64'd0);
  endtask

  initial begin
    bus.s_rx_tdata   = '0;
    bus.s_rx_tvalid  = 1'b0;
    bus.m_rsp_tready = 1'b0;
    exp_err          = '0;
    repeat (3) tick();
    chk_reset_values("reset");
    i_rst        = 1'b1;
    i_sfp_master = 1'b1;
    i_channel_up = 1'b1;
    tick();

    // T1: clean burst on slave 1
    for (int i = 0; i < 8; i++) send_tlm(2'd1, 4'(i), 32'hA0 + 32'(i));
    chk("t1_no_early_update", 64'(o_update), 64'd0);
    chk("t1_collecting", 64'(o_dbg_collect), 64'b001);
    send_tlm(2'd1, 4'd8, 32'hA8);
    chk("t1_update", 64'(o_update), 64'b001);
    chk("t1_alive", 64'(o_alive), 64'b001);
    rd("t1_rd_1_5", 2'd1, 4'd5, 32'hA5);
    chk("t1_update_pulse_end", 64'(o_update), 64'd0);
    rd("t1_rd_1_8", 2'd1, 4'd8, 32'hA8);
    rd("t1_rd_idx9", 2'd1, 4'd9, 32'h0);
    rd("t1_rd_slave0", 2'd0, 4'd0, 32'h0);

    // T2: slave 2 skips index 3
    send_tlm(2'd2, 4'd0, 32'hB0);
    send_tlm(2'd2, 4'd1, 32'hB1);
    send_tlm(2'd2, 4'd2, 32'hB2);
    send_tlm(2'd2, 4'd4, 32'hB4);
    exp_err = 16'd1;
    chk("t2_err", 64'(o_seq_err_cnt), 64'(exp_err));
    chk("t2_no_update", 64'(o_update), 64'd0);
    chk("t2_idle", 64'(o_dbg_collect), 64'd0);
    rd("t2_rd_2_0", 2'd2, 4'd0, 32'h0);
    chk("t2_alive", 64'(o_alive), 64'b001);

    // T3: slaves 1 and 3 interleaved
    for (int i = 0; i < 9; i++) begin
      send_tlm(2'd1, 4'(i), 32'hC0 + 32'(i));
      if (i == 8) chk("t3_update_s1", 64'(o_update), 64'b001);
      send_tlm(2'd3, 4'(i), 32'hD0 + 32'(i));
      if (i == 8) chk("t3_update_s3", 64'(o_update), 64'b100);
    end
    chk("t3_err", 64'(o_seq_err_cnt), 64'(exp_err));
    rd("t3_rd_1_3", 2'd1, 4'd3, 32'hC3);
    rd("t3_rd_3_7", 2'd3, 4'd7, 32'hD7);
    rd("t3_rd_3_0", 2'd3, 4'd0, 32'hD0);

    // T4: response FIFO overflow, push-with-pop when full, in-order drain
    for (int j = 0; j < 5; j++) send_raw({RSP_HDR, 32'(j)});
    chk("t4_drop", 64'(o_rsp_drop_cnt), 64'd1);
    chk("t4_tvalid", 64'(bus.m_rsp_tvalid), 64'd1);
    chk("t4_head0", bus.m_rsp_tdata, {RSP_HDR, 32'd0});
    bus.m_rsp_tready = 1'b1;
    send_raw({RSP_HDR, 32'd5});
    chk("t4_full_push_pop_nodrop", 64'(o_rsp_drop_cnt), 64'd1);
    exp_heads = '{32'd1, 32'd2, 32'd3, 32'd5};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_head_%0d", k), bus.m_rsp_tdata, {RSP_HDR, exp_heads[k]});
      tick();
    end
    chk("t4_empty", 64'(bus.m_rsp_tvalid), 64'd0);
    chk("t4_empty_data", bus.m_rsp_tdata, 64'd0);
    send_raw(64'h0200_0003_1234_5678);
    chk("t4_id0_to_fifo", bus.m_rsp_tdata, 64'h0200_0003_1234_5678);
    chk("t4_id0_no_err", 64'(o_seq_err_cnt), 64'(exp_err));
    tick();
    chk("t4_id0_popped", 64'(bus.m_rsp_tvalid), 64'd0);

    // T6: channel loss mid-burst, then a full burst
    for (int i = 0; i < 5; i++) send_tlm(2'd2, 4'(i), 32'h99);
    chk("t6_collecting", 64'(o_dbg_collect), 64'b010);
    i_channel_up = 1'b0;
    tick();
    chk("t6_flushed", 64'(o_dbg_collect), 64'd0);
    i_channel_up = 1'b1;
    for (int i = 0; i < 9; i++) send_tlm(2'd2, 4'(i), 32'hE0 + 32'(i));
    chk("t6_update", 64'(o_update), 64'b010);
    chk("t6_err", 64'(o_seq_err_cnt), 64'(exp_err));
    rd("t6_rd_2_4", 2'd2, 4'd4, 32'hE4);
    chk("t6_single_commit", 64'(o_update), 64'd0);

    // Inter-frame timeout: error on the 16th frameless clock
    send_tlm(2'd3, 4'd0, 32'h77);
    repeat (15) tick();
    chk("to_not_yet", 64'(o_seq_err_cnt), 64'(exp_err));
    chk("to_still_collect", 64'(o_dbg_collect), 64'b100);
    tick();
    exp_err = exp_err + 16'd1;
    chk("to_err", 64'(o_seq_err_cnt), 64'(exp_err));
    chk("to_idle", 64'(o_dbg_collect), 64'd0);
    rd("to_bank_kept", 2'd3, 4'd0, 32'hD0);

    // Non-zero index while idle
    send_tlm(2'd1, 4'd3, 32'h55);
    exp_err = exp_err + 16'd1;
    chk("idle_bad_idx_err", 64'(o_seq_err_cnt), 64'(exp_err));

    // Restart inside a burst, then commit and time liveness from the commit edge
    send_tlm(2'd1, 4'd0, 32'h11);
    send_tlm(2'd1, 4'd0, 32'hF0);
    exp_err = exp_err + 16'd1;
    chk("restart_err", 64'(o_seq_err_cnt), 64'(exp_err));
    for (int i = 1; i < 9; i++) send_tlm(2'd1, 4'(i), 32'hF0 + 32'(i));
    chk("t5_update", 64'(o_update), 64'b001);
    repeat (ALIVE_TO - 1) tick();
    chk("t5_alive_before", 64'(o_alive[0]), 64'd1);
    tick();
    chk("t5_alive_after", 64'(o_alive[0]), 64'd0);
    rd("t5_rd_1_0", 2'd1, 4'd0, 32'hF0);
    rd("t5_rd_1_8", 2'd1, 4'd8, 32'hF8);

    // Asynchronous reset in the middle of a burst
    bus.m_rsp_tready = 1'b0;
    send_raw({RSP_HDR, 32'hAB});
    for (int i = 0; i < 4; i++) send_tlm(2'd2, 4'(i), 32'h42);
    #2;
    i_rst = 1'b0;
    #1;
    chk_reset_values("midrst");
    tick();
    i_rst = 1'b1;
    rd("midrst_bank_cleared", 2'd1, 4'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
